state_report_tx: RTL and testbench
==================================

// Module: state_report_tx
// PURPOSE
//   UART transmit side of the host link. The state machine consumes 0x5A command bytes from the
//   host; this block reports its state byte back to the host. It watches the 8-bit state code
//   (01 wait / 02 transport / 03 display) and sends a 3-byte frame on change or on request.
//   Frame = HEADER, state, HEADER^state, each byte 8N1, LSB first. Built-in bit serializer.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD       115200      UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, >=2)
//   HEADER     8'hA5       frame header byte
// PORTS
//   i_clk_sys     in   1  system clock; all logic on posedge, single clock domain
//   i_rst         in   1  synchronous reset, active-high
//   i_state       in   8  current state code from the state machine (registered, clk_sys domain)
//   i_query       in   1  one-cycle pulse: host request to resend the current state
//   o_tx          out  1  UART TX line, idle high
//   o_busy        out  1  high while a frame is in progress
//   o_frame_done  out  1  one-cycle pulse when the final stop bit of a frame completes
// BEHAVIOUR
//   Reset (i_rst high at a clock edge):
//     o_tx=1, o_busy=0, o_frame_done=0, last_sent=8'h01, pending=0, FSM=IDLE.
//     Reset dominates and aborts any frame immediately. No frame follows reset unless a trigger occurs.
//   Trigger, evaluated every cycle:
//     trig = (i_state != last_sent) | i_query | pending.
//   IDLE with trig at cycle N:
//     latch snap=i_state; last_sent=i_state; clear pending.
//     o_tx=0 (start bit) and o_busy=1 from cycle N+1.
//   FSM states: IDLE -> START -> DATA (8 bits, bit0 first) -> STOP -> next byte START, or IDLE after byte 2.
//     Byte index 0..2 selects HEADER / snap / HEADER^snap.
//   Bit timing:
//     every bit, including start and stop, holds exactly CLKS_PER_BIT cycles.
//     Frame = 30*CLKS_PER_BIT cycles, contiguous, no idle gap between bytes.
//   Frame end:
//     on the last cycle of byte-2's stop bit, the next edge returns to IDLE.
//     At that edge o_frame_done pulses 1 cycle and o_busy drops; o_tx stays 1.
//   During a frame:
//     i_query, or i_state != snap, sets pending. Extra events while pending=1 merge into one.
//     snap is never updated mid-frame, so the transmitted bytes stay self-consistent.
//   Back-to-back frames:
//     if pending at frame end, IDLE lasts exactly 1 cycle (o_busy=0, o_tx=1, o_frame_done=1).
//     The new start bit begins on the following cycle with a fresh snap.
//   A re-sent identical state is allowed, for example a query with no change.
//     A change that reverts to last_sent before the frame ends still produces one frame; pending is sticky.
//   Simultaneous i_query and a state change in IDLE produce exactly one frame.
//   Counters:
//     bit-time counter sized clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1.
//     Bit counter 0..7; byte counter 0..2. No counter may overflow past these bounds.
// TESTING (sim with CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10)
//   1. Reset, hold i_state=01 for 500 cycles -> o_tx stays 1, o_busy 0, no o_frame_done.
//   2. i_state 01->02 -> line decodes A5,02,A7. o_busy high 300 cycles. One o_frame_done pulse at frame end.
//   3. i_state=03 idle, pulse i_query -> frame A5,03,A6. Query and change in the same cycle -> exactly one frame.
//   4. Mid-frame, i_state 02->03 plus 2 queries -> current frame unchanged.
//      1 idle cycle, then exactly one frame A5,03,A6, then idle.
//   5. Assert i_rst mid-DATA bit -> next cycle o_tx=1, o_busy=0. No frame resumes while i_state=01.
//   6. Bit timing: every start/data/stop bit measured at exactly 10 cycles. Stop bits sampled high.

Source files
------------

// File: rtl/state_report_tx.sv
// UART transmit side of the host link: sends a 3-byte state report frame
// (HEADER, state, HEADER^state; 8N1, LSB first) when the state changes or on request.
module state_report_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic       i_clk_sys,
    input  logic       i_rst,
    input  logic [7:0] i_state,
    input  logic       i_query,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [CntW-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       snap_q, snap_d;
    logic [7:0]       last_sent_q, last_sent_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;

    logic             bit_end;
    logic             trig;
    logic [7:0]       cur_byte;

    assign bit_end = (baud_cnt_q == CntMax);
    assign trig    = (i_state != last_sent_q) | i_query | pending_q;

    always_comb begin
        unique case (byte_idx_q)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = snap_q;
            2'd2:    cur_byte = HEADER ^ snap_q;
            default: cur_byte = HEADER;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        snap_d       = snap_q;
        last_sent_d  = last_sent_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d     = StStart;
                    snap_d      = i_state;
                    last_sent_d = i_state;
                    pending_d   = 1'b0;
                    baud_cnt_d  = '0;
                    bit_idx_d   = '0;
                    byte_idx_d  = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == 2'd2) begin
                        byte_idx_d   = '0;
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = StStart;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // snap is frozen mid-frame; any new request is remembered for the next frame
        if (state_q != StIdle && (i_query || (i_state != snap_q))) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q      <= StIdle;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            snap_q       <= 8'h01;
            last_sent_q  <= 8'h01;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            snap_q       <= snap_d;
            last_sent_q  <= last_sent_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        case (state_q)
            StStart: o_tx = 1'b0;
            StData:  o_tx = cur_byte[bit_idx_q];
            default: o_tx = 1'b1;
        endcase
    end

    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_state_report_tx.sv
// Self-checking bench for state_report_tx: decodes the TX line per clock and compares
// each frame against a scoreboard of expected bytes.
module tb_state_report_tx;

    localparam int unsigned FrameLen = 300;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_state;
    logic       i_query;
    logic       o_tx;
    logic       o_busy;
    logic       o_frame_done;

    always #5 clk = ~clk;

    state_report_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .HEADER   (8'hA5)
    ) dut (
        .i_clk_sys    (clk),
        .i_rst        (i_rst),
        .i_state      (i_state),
        .i_query      (i_query),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       tx_s   [0:FrameLen];
    logic       busy_s [0:FrameLen];
    logic       done_s [0:FrameLen];
    logic       cap_got;

    // Waits (bounded) for a start bit, then records FrameLen+1 consecutive cycles.
    task automatic capture_frame(input int budget);
        int waited;
        waited  = 0;
        cap_got = 1'b0;
        while (o_tx !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (o_tx === 1'b0) begin
            cap_got = 1'b1;
            for (int i = 0; i <= FrameLen; i++) begin
                tx_s[i]   = o_tx;
                busy_s[i] = o_busy;
                done_s[i] = o_frame_done;
                if (i < FrameLen) @(negedge clk);
            end
        end
    endtask

    function automatic logic [7:0] rx_byte(input int b);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = tx_s[(10 * b + 1 + j) * 10 + 5];
        return v;
    endfunction

    function automatic bit timing_ok();
        for (int k = 0; k < 30; k++)
            for (int s = 1; s < 10; s++)
                if (tx_s[k * 10 + s] !== tx_s[k * 10]) return 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (tx_s[(10 * b) * 10] !== 1'b0) return 1'b0;
            if (tx_s[(10 * b + 9) * 10] !== 1'b1) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < FrameLen; i++) if (busy_s[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 0; i <= FrameLen; i++) if (done_s[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        int bad_tx, bad_busy, bad_done;
        i_rst   = 1'b1;
        i_state = 8'h01;
        i_query = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tx=%b busy=%b done=%b expected 1/0/0",
                     o_tx, o_busy, o_frame_done);
        end
        i_rst = 1'b0;
        bad_tx = 0; bad_busy = 0; bad_done = 0;
        repeat (500) begin
            @(negedge clk);
            if (o_tx !== 1'b1) bad_tx++;
            if (o_busy !== 1'b0) bad_busy++;
            if (o_frame_done !== 1'b0) bad_done++;
        end
        tests_run++;
        if (bad_tx != 0 || bad_busy != 0 || bad_done != 0) begin
            tests_failed++;
            $display("FAIL reset_idle_500: got tx_low=%0d busy=%0d done=%0d cycles expected 0",
                     bad_tx, bad_busy, bad_done);
        end
    endtask

    task automatic test_state_change();
        logic [7:0] e, g;
        @(negedge clk);
        i_state = 8'h02;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'hA7);
        capture_frame(20);
        tests_run++;
        if (!cap_got) begin
            tests_failed++;
            $display("FAIL change_start: got no start bit expected frame");
            exp_q.delete();
        end else begin
            for (int b = 0; b < 3; b++) begin
                e = pop_exp(); g = rx_byte(b);
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL change_byte%0d: got %h expected %h", b, g, e);
                end
            end
            tests_run++;
            if (!timing_ok()) begin
                tests_failed++;
                $display("FAIL change_bit_timing: got bad bit timing expected 10 cycles/bit");
            end
            tests_run++;
            if (count_busy() != FrameLen || busy_s[FrameLen] !== 1'b0) begin
                tests_failed++;
                $display("FAIL change_busy: got %0d busy cycles end=%b expected 300 end=0",
                         count_busy(), busy_s[FrameLen]);
            end
            tests_run++;
            if (count_done() != 1 || done_s[FrameLen] !== 1'b1 || tx_s[FrameLen] !== 1'b1) begin
                tests_failed++;
                $display("FAIL change_frame_done: got %0d pulses end=%b tx=%b expected 1/1/1",
                         count_done(), done_s[FrameLen], tx_s[FrameLen]);
            end
        end
        capture_frame(50);
        tests_run++;
        if (cap_got || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL change_no_extra: got extra frame=%b busy=%b expected 0/0",
                     cap_got, o_busy);
        end
    endtask

    task automatic test_query();
        logic [7:0] e, g;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            if (pass == 0) i_state = 8'h03;
            i_query = 1'b1;
            exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'hA6);
            @(negedge clk);
            i_query = 1'b0;
            capture_frame(20);
            tests_run++;
            if (!cap_got) begin
                tests_failed++;
                $display("FAIL query%0d_start: got no start bit expected frame", pass);
                exp_q.delete();
            end else begin
                for (int b = 0; b < 3; b++) begin
                    e = pop_exp(); g = rx_byte(b);
                    tests_run++;
                    if (g !== e) begin
                        tests_failed++;
                        $display("FAIL query%0d_byte%0d: got %h expected %h", pass, b, g, e);
                    end
                end
                tests_run++;
                if (!timing_ok() || count_busy() != FrameLen || count_done() != 1) begin
                    tests_failed++;
                    $display("FAIL query%0d_frame_shape: got timing=%b busy=%0d done=%0d expected 1/300/1",
                             pass, timing_ok(), count_busy(), count_done());
                end
            end
            capture_frame(100);
            tests_run++;
            if (cap_got) begin
                tests_failed++;
                $display("FAIL query%0d_single_frame: got second frame expected none", pass);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, g;
        @(negedge clk);
        i_state = 8'h02;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'hA7);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h03); exp_q.push_back(8'hA6);
        fork
            capture_frame(20);
            begin
                repeat (100) @(negedge clk);
                i_state = 8'h03;
                i_query = 1'b1;
                @(negedge clk);
                i_query = 1'b0;
                repeat (50) @(negedge clk);
                i_query = 1'b1;
                @(negedge clk);
                i_query = 1'b0;
            end
        join
        for (int f = 0; f < 2; f++) begin
            tests_run++;
            if (!cap_got) begin
                tests_failed++;
                $display("FAIL b2b_frame%0d_start: got no start bit expected frame", f);
                exp_q.delete();
            end else begin
                for (int b = 0; b < 3; b++) begin
                    e = pop_exp(); g = rx_byte(b);
                    tests_run++;
                    if (g !== e) begin
                        tests_failed++;
                        $display("FAIL b2b_frame%0d_byte%0d: got %h expected %h", f, b, g, e);
                    end
                end
                tests_run++;
                if (!timing_ok() || count_busy() != FrameLen || done_s[FrameLen] !== 1'b1 ||
                    busy_s[FrameLen] !== 1'b0 || tx_s[FrameLen] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_frame%0d_end: got timing=%b busy=%0d done=%b expected 1/300/1",
                             f, timing_ok(), count_busy(), done_s[FrameLen]);
                end
            end
            if (f == 0) begin
                @(negedge clk);
                tests_run++;
                if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_one_idle_cycle: got tx=%b busy=%b expected 0/1",
                             o_tx, o_busy);
                end
                capture_frame(2);
            end
        end
        capture_frame(100);
        tests_run++;
        if (cap_got) begin
            tests_failed++;
            $display("FAIL b2b_merged: got third frame expected none");
        end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        @(negedge clk);
        i_state = 8'h01;
        waited  = 0;
        while (o_tx !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (35) @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_busy: got busy=%b expected 1 before reset", o_busy);
        end
        i_rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: got tx=%b busy=%b done=%b expected 1/0/0",
                     o_tx, o_busy, o_frame_done);
        end
        i_rst = 1'b0;
        capture_frame(200);
        tests_run++;
        if (cap_got || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_resume: got frame=%b busy=%b expected 0/0", cap_got, o_busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_state_change();
        test_query();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
